// File: rtl/wb_cmd_master.sv
// Single-command Wishbone classic master: accepts one read/write command, runs it on the
// bus with retry/backoff and timeout handling, and returns one response per command.
module wb_cmd_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255,
    parameter int MAX_RETRY  = 3
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_adr,
    input  logic [DATA_WIDTH-1:0] cmd_dat,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_dat,
    output logic [1:0]            rsp_status,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_we_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic [2:0]            wb_cti_o,
    output logic [1:0]            wb_bte_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS     = 2'd1,
        BACKOFF = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [1:0]  ST_OK      = 2'b00;
    localparam logic [1:0]  ST_ERR     = 2'b01;
    localparam logic [1:0]  ST_TIMEOUT = 2'b10;
    localparam logic [1:0]  ST_RTY_EXH = 2'b11;
    localparam logic [15:0] TIMER_LAST  = 16'(TIMEOUT - 1);
    localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRY);

    state_t                  state_r, state_s;
    logic [15:0]             timer_r, timer_s;
    logic [3:0]              retry_r, retry_s;
    logic [ADDR_WIDTH-1:0]   adr_s;
    logic [DATA_WIDTH-1:0]   dat_s;
    logic                    we_s;
    logic                    cyc_s;
    logic                    ready_s;
    logic                    busy_s;
    logic                    rsp_valid_s;
    logic [DATA_WIDTH-1:0]   rsp_dat_s;
    logic [1:0]              rsp_status_s;

    assign wb_cti_o = 3'b000;
    assign wb_bte_o = 2'b00;

    // Next-state and next-output logic; every output register is loaded from these values.
    always_comb begin
        state_s      = state_r;
        timer_s      = timer_r;
        retry_s      = retry_r;
        adr_s        = wb_adr_o;
        dat_s        = wb_dat_o;
        we_s         = wb_we_o;
        rsp_valid_s  = rsp_valid;
        rsp_dat_s    = rsp_dat;
        rsp_status_s = rsp_status;
        case (state_r)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    adr_s   = cmd_adr;
                    dat_s   = cmd_dat;
                    we_s    = cmd_we;
                    retry_s = 4'd0;
                    timer_s = 16'd0;
                    state_s = BUS;
                end else begin
                    state_s = IDLE;
                end
            end
            BUS: begin
                // Terminations beat the timer expiring in the same cycle.
                if (wb_ack_i) begin
                    rsp_dat_s    = wb_we_o ? {DATA_WIDTH{1'b0}} : wb_dat_i;
                    rsp_status_s = ST_OK;
                    rsp_valid_s  = 1'b1;
                    state_s      = RESP;
                end else if (wb_err_i) begin
                    rsp_dat_s    = {DATA_WIDTH{1'b0}};
                    rsp_status_s = ST_ERR;
                    rsp_valid_s  = 1'b1;
                    state_s      = RESP;
                end else if (wb_rty_i) begin
                    if (retry_r < RETRY_LIMIT) begin
                        retry_s = retry_r + 4'd1;
                        timer_s = 16'd0;
                        state_s = BACKOFF;
                    end else begin
                        rsp_dat_s    = {DATA_WIDTH{1'b0}};
                        rsp_status_s = ST_RTY_EXH;
                        rsp_valid_s  = 1'b1;
                        state_s      = RESP;
                    end
                end else if (timer_r == TIMER_LAST) begin
                    rsp_dat_s    = {DATA_WIDTH{1'b0}};
                    rsp_status_s = ST_TIMEOUT;
                    rsp_valid_s  = 1'b1;
                    state_s      = RESP;
                end else begin
                    timer_s = timer_r + 16'd1;
                end
            end
            BACKOFF: begin
                state_s = BUS;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_s = 1'b0;
                    state_s     = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        cyc_s   = (state_s == BUS);
        ready_s = (state_s == IDLE);
        busy_s  = (state_s != IDLE);
    end

    // State, counters and all registered outputs, with synchronous reset.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_r    <= IDLE;
            timer_r    <= 16'd0;
            retry_r    <= 4'd0;
            wb_adr_o   <= {ADDR_WIDTH{1'b0}};
            wb_dat_o   <= {DATA_WIDTH{1'b0}};
            wb_we_o    <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_dat    <= {DATA_WIDTH{1'b0}};
            rsp_status <= ST_OK;
        end else begin
            state_r    <= state_s;
            timer_r    <= timer_s;
            retry_r    <= retry_s;
            wb_adr_o   <= adr_s;
            wb_dat_o   <= dat_s;
            wb_we_o    <= we_s;
            wb_cyc_o   <= cyc_s;
            wb_stb_o   <= cyc_s;
            cmd_ready  <= ready_s;
            busy       <= busy_s;
            rsp_valid  <= rsp_valid_s;
            rsp_dat    <= rsp_dat_s;
            rsp_status <= rsp_status_s;
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed, table-driven bench for wb_cmd_master (TIMEOUT=8, MAX_RETRY=2) with a
// configurable Wishbone slave model and hand-written reset/idle sequences.
`timescale 1ns/1ps
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        wb_rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr;
    logic [7:0]  cmd_dat;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_dat;
    logic [1:0]  rsp_status;
    logic [31:0] wb_adr_o;
    logic [7:0]  wb_dat_o, wb_dat_i;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i;
    logic        busy;

    // slave model configuration
    logic        sl_ack = 1'b0, sl_err = 1'b0, sl_rty = 1'b0, sl_force = 1'b0;
    int          sl_wait = 0;
    logic [7:0]  sl_rdata = 8'h00;
    int          stb_cnt = 0;
    logic        hit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(8), .TIMEOUT(8), .MAX_RETRY(2)) dut (
        .wb_clk(clk), .wb_rst(wb_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_status(rsp_status),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .busy(busy)
    );

    // counts strobe cycles within the current attempt
    always @(posedge clk) stb_cnt <= wb_stb_o ? stb_cnt + 1 : 0;

    assign hit      = wb_cyc_o && wb_stb_o && (stb_cnt == sl_wait);
    assign wb_ack_i = (hit && sl_ack) || sl_force;
    assign wb_err_i = (hit && sl_err) || sl_force;
    assign wb_rty_i = (hit && sl_rty) || sl_force;
    assign wb_dat_i = hit ? sl_rdata : 8'h3C;

    // term: 0 none, 1 ack, 2 err, 3 rty, 4 ack+err, 5 ack+rty
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [7:0]  dat;
        int          term;
        int          wait_c;
        logic [7:0]  rdata;
        int          hold;
        logic [1:0]  exp_status;
        logic [7:0]  exp_dat;
        int          exp_cyc;
        int          exp_rises;
        int          exp_span;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   cyc_n, rises, first_t, last_t, bad, bad_hold;
        logic prev;
        bit   done;
        sl_ack   = (v.term == 1 || v.term == 4 || v.term == 5);
        sl_err   = (v.term == 2 || v.term == 4);
        sl_rty   = (v.term == 3 || v.term == 5);
        sl_wait  = v.wait_c;
        sl_rdata = v.rdata;
        @(negedge clk);
        chk($sformatf("v%0d_idle_ready", idx), cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_adr   = v.adr;
        cmd_dat   = v.dat;
        cyc_n = 0; rises = 0; first_t = -1; last_t = -1; bad = 0; prev = 1'b0; done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                if (wb_cyc_o) begin
                    cyc_n++;
                    if (!prev) rises++;
                    if (first_t < 0) first_t = c;
                    last_t = c;
                    if (wb_stb_o !== 1'b1 || wb_adr_o !== v.adr || wb_dat_o !== v.dat || wb_we_o !== v.we)
                        bad++;
                end else if (wb_stb_o !== 1'b0) begin
                    bad++;
                end
                if (cmd_ready !== 1'b0 || busy !== 1'b1) bad++;
                prev = wb_cyc_o;
            end
        end
        chk($sformatf("v%0d_rsp_seen", idx), done, 1);
        chk($sformatf("v%0d_status", idx), rsp_status, v.exp_status);
        chk($sformatf("v%0d_rsp_dat", idx), rsp_dat, v.exp_dat);
        chk($sformatf("v%0d_cyc_cycles", idx), cyc_n, v.exp_cyc);
        chk($sformatf("v%0d_attempts", idx), rises, v.exp_rises);
        chk($sformatf("v%0d_span", idx), last_t - first_t + 1, v.exp_span);
        chk($sformatf("v%0d_bus_hold", idx), bad, 0);
        bad_hold = 0;
        sl_force = (v.hold > 0);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_dat !== v.exp_dat || rsp_status !== v.exp_status ||
                cmd_ready !== 1'b0 || wb_cyc_o !== 1'b0)
                bad_hold++;
        end
        sl_force = 1'b0;
        if (v.hold > 0) chk($sformatf("v%0d_resp_stable", idx), bad_hold, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk($sformatf("v%0d_rsp_clear", idx), rsp_valid, 0);
        chk($sformatf("v%0d_ready_back", idx), cmd_ready, 1);
        chk($sformatf("v%0d_not_busy", idx), busy, 0);
    endtask

    initial begin
        int seen;
        //          we    adr     dat   term wait rdata  hold st     dat   cyc rises span
        vecs[0] = '{1'b1, 32'h04, 8'hFF, 1, 0, 8'h77, 0, 2'b00, 8'h00, 1, 1, 1};
        vecs[1] = '{1'b0, 32'h00, 8'h11, 1, 3, 8'hA5, 0, 2'b00, 8'hA5, 4, 1, 4};
        vecs[2] = '{1'b0, 32'h10, 8'h22, 3, 0, 8'h44, 0, 2'b11, 8'h00, 3, 3, 5};
        vecs[3] = '{1'b0, 32'h20, 8'h33, 0, 0, 8'h55, 0, 2'b10, 8'h00, 8, 1, 8};
        vecs[4] = '{1'b0, 32'h24, 8'h44, 1, 7, 8'h5A, 0, 2'b00, 8'h5A, 8, 1, 8};
        vecs[5] = '{1'b0, 32'h30, 8'h55, 4, 1, 8'hC3, 0, 2'b00, 8'hC3, 2, 1, 2};
        vecs[6] = '{1'b1, 32'h34, 8'h66, 2, 2, 8'h81, 0, 2'b01, 8'h00, 3, 1, 3};
        vecs[7] = '{1'b0, 32'h40, 8'h77, 1, 0, 8'h96, 5, 2'b00, 8'h96, 1, 1, 1};
        vecs[8] = '{1'b0, 32'h50, 8'h88, 3, 2, 8'h12, 0, 2'b11, 8'h00, 9, 3, 11};
        vecs[9] = '{1'b1, 32'h60, 8'h99, 5, 0, 8'h34, 0, 2'b00, 8'h00, 1, 1, 1};

        wb_rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_dat = 8'h0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_dat", rsp_dat, 0);
        chk("rst_status", rsp_status, 0);
        chk("rst_busy", busy, 0);
        chk("cti", wb_cti_o, 0);
        chk("bte", wb_bte_o, 0);
        wb_rst = 1'b0;
        @(negedge clk);
        chk("rel_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // terminations while idle must be ignored
        sl_force = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_term_busy", busy, 0);
        chk("idle_term_rsp", rsp_valid, 0);
        chk("idle_term_cyc", wb_cyc_o, 0);
        chk("idle_term_ready", cmd_ready, 1);
        sl_force = 1'b0;

        // reset in the middle of a bus attempt aborts without a response
        sl_ack = 1'b0; sl_err = 1'b0; sl_rty = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h70; cmd_dat = 8'hAA;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_cyc_up", wb_cyc_o, 1);
        repeat (2) @(negedge clk);
        wb_rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_cyc", wb_cyc_o, 0);
        chk("mid_rst_stb", wb_stb_o, 0);
        chk("mid_rst_rsp", rsp_valid, 0);
        chk("mid_rst_ready", cmd_ready, 0);
        chk("mid_rst_busy", busy, 0);
        wb_rst = 1'b0;
        @(negedge clk);
        chk("mid_rel_ready", cmd_ready, 1);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid || wb_cyc_o) seen++;
        end
        chk("mid_no_response", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
